// File: rtl/rx.sv
// UART receiver: start, 8 data bits LSB first, parity, 1 stop; mid-bit sampling.
// Optional two-flop input synchronizer when RX_SYNC_EN is defined.
module rx #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 19_200,
  parameter logic        PARITY        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       data_strobe,
  output logic       rx_error
);

  localparam int unsigned BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF_CLOCKS = BAUD_CLOCKS / 2;
  localparam int unsigned CNT_W       = (BAUD_CLOCKS > 1) ? $clog2(BAUD_CLOCKS) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic             din_s;
  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shreg, shreg_d;
  logic             perr, perr_d;
  logic [7:0]       dout_d;
  logic             busy_d;
  logic             strobe_d;
  logic             err_d;

`ifdef RX_SYNC_EN
  // Metastability guard; resets to the idle line level so reset does not look like a start bit.
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], din};
    end
  end

  assign din_s = sync[1];
`else
  assign din_s = din;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      perr        <= 1'b0;
      dout        <= '0;
      busy        <= 1'b0;
      data_strobe <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_idx_d;
      shreg       <= shreg_d;
      perr        <= perr_d;
      dout        <= dout_d;
      busy        <= busy_d;
      data_strobe <= strobe_d;
      rx_error    <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    perr_d    = perr;
    dout_d    = dout;
    busy_d    = busy;
    strobe_d  = 1'b0;
    err_d     = rx_error;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (!din_s) begin
          state_d = START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (cnt == CNT_W'(HALF_CLOCKS - 1)) begin
          cnt_d = '0;
          if (din_s) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == CNT_W'(BAUD_CLOCKS - 1)) begin
          cnt_d   = '0;
          shreg_d = {din_s, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = PAR;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      PAR: begin
        if (cnt == CNT_W'(BAUD_CLOCKS - 1)) begin
          cnt_d   = '0;
          perr_d  = ((^shreg) ^ din_s) != PARITY;
          state_d = STOP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        // Leave at mid-stop so an immediately following start bit is caught.
        if (cnt == CNT_W'(BAUD_CLOCKS - 1)) begin
          cnt_d    = '0;
          dout_d   = shreg;
          strobe_d = 1'b1;
          err_d    = perr | ~din_s;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx: bit-banged frames at 16 clocks per bit, hand-computed expectations.
module tb_rx;

  localparam int unsigned B = 16;
`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int NOM_LAT = (21 * B) / 2 + SYNC_LAT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b1;
  logic [7:0] dout;
  logic       busy;
  logic       data_strobe;
  logic       rx_error;

  int         n_cmp = 0;
  int         n_err = 0;
  int         strobes = 0;
  int         cyc = 0;
  int         strobe_cyc = 0;
  int         start_cyc = 0;
  logic [7:0] last_dout = 8'h00;
  logic       last_err = 1'b0;
  logic       busy_seen = 1'b0;
  int         base;
  int         lat;

  always #5 clk = ~clk;

  rx #(
    .CLK_FREQUENCY(1_600_000),
    .BAUD_RATE    (100_000),
    .PARITY       (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dout       (dout),
    .busy       (busy),
    .data_strobe(data_strobe),
    .rx_error   (rx_error)
  );

  // Strobe and busy monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (data_strobe) begin
      strobes    = strobes + 1;
      strobe_cyc = cyc;
      last_dout  = dout;
      last_err   = rx_error;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic send_bit(input logic b);
    din = b;
    repeat (B) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_strobe", 32'(data_strobe), 32'h0);
    check("reset_err", 32'(rx_error), 32'h0);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);

    // 1: good frame 0xA5, also checks strobe latency
    base = strobes;
    send_frame(8'hA5, 1'b1, 1'b1);
    lat = strobe_cyc - start_cyc;
    send_bit(1'b1);
    check("t1_strobes", 32'(strobes - base), 32'd1);
    check("t1_dout", 32'(last_dout), 32'hA5);
    check("t1_err", 32'(last_err), 32'h0);
    check("t1_busy_after", 32'(busy), 32'h0);
    check("t1_latency_ok", 32'((lat >= NOM_LAT - 2) && (lat <= NOM_LAT + 2)), 32'h1);

    // 2: parity error, then a good copy clears the flag
    base = strobes;
    send_frame(8'h3C, 1'b0, 1'b1);
    send_bit(1'b1);
    check("t2_bad_strobes", 32'(strobes - base), 32'd1);
    check("t2_bad_dout", 32'(last_dout), 32'h3C);
    check("t2_bad_err", 32'(last_err), 32'h1);
    send_frame(8'h3C, odd_par(8'h3C), 1'b1);
    send_bit(1'b1);
    check("t2_good_strobes", 32'(strobes - base), 32'd2);
    check("t2_good_err", 32'(last_err), 32'h0);

    // 3: framing error, line high 2 bit times, then 0x00
    base = strobes;
    send_frame(8'h81, odd_par(8'h81), 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("t3_fe_strobes", 32'(strobes - base), 32'd1);
    check("t3_fe_dout", 32'(last_dout), 32'h81);
    check("t3_fe_err", 32'(last_err), 32'h1);
    send_frame(8'h00, odd_par(8'h00), 1'b1);
    send_bit(1'b1);
    check("t3_ok_strobes", 32'(strobes - base), 32'd2);
    check("t3_ok_dout", 32'(last_dout), 32'h00);
    check("t3_ok_err", 32'(last_err), 32'h0);

    // 4: glitch shorter than half a bit is a false start
    send_frame(8'h6E, odd_par(8'h6E), 1'b1);
    send_bit(1'b1);
    base = strobes;
    busy_seen = 1'b0;
    din = 1'b0;
    repeat (B / 4) @(negedge clk);
    din = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("t4_busy_pulse", 32'(busy_seen), 32'h1);
    check("t4_busy_low", 32'(busy), 32'h0);
    check("t4_no_strobe", 32'(strobes - base), 32'd0);
    check("t4_dout_kept", 32'(dout), 32'h6E);

    // 5: back-to-back frames, no idle gap
    base = strobes;
    send_frame(8'hFF, odd_par(8'hFF), 1'b1);
    check("t5_first_dout", 32'(last_dout), 32'hFF);
    check("t5_first_err", 32'(last_err), 32'h0);
    send_frame(8'h01, odd_par(8'h01), 1'b1);
    send_bit(1'b1);
    check("t5_strobes", 32'(strobes - base), 32'd2);
    check("t5_second_dout", 32'(last_dout), 32'h01);
    check("t5_second_err", 32'(last_err), 32'h0);

    // 6: reset in the middle of data bit 4 of 0x5A
    base = strobes;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
    din = 1'(8'h5A >> 4);
    repeat (B / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_dout", 32'(dout), 32'h00);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_strobe", 32'(data_strobe), 32'h0);
    check("t6_rst_err", 32'(rx_error), 32'h0);
    din = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("t6_aborted_no_strobe", 32'(strobes - base), 32'd0);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    send_bit(1'b1);
    check("t6_strobes", 32'(strobes - base), 32'd1);
    check("t6_dout", 32'(last_dout), 32'h5A);
    check("t6_err", 32'(last_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
